// File: rtl/slot_spin_ctrl.sv
// slot_spin_ctrl: slot-machine play sequencer owning the balance, reels, bet debit and payout.
// Define SLOT_PAIR_REFUND_EN to refund the bet when reels 1 and 2 match without a jackpot.
module slot_spin_ctrl #(
   parameter int SPIN_CYCLES   = 8,
   parameter int START_BALANCE = 100,
   parameter int PAYOUT_MULT   = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spin,
   input  logic        b1,
   input  logic        b10,
   input  logic        b50,
   input  logic        b100,
   input  logic [3:0]  rnd,
   output logic [3:0]  randNum1,
   output logic [3:0]  randNum2,
   output logic [3:0]  randNum3,
   output logic [3:0]  randNum4,
   output logic [26:0] balance,
   output logic        busy,
   output logic        win,
   output logic        done,
   output logic        nofunds
);
   localparam int CW = $clog2(4*SPIN_CYCLES+1);
   localparam logic [26:0] BMAX = '1;
   typedef enum logic [2:0] {IDLE, DEBIT, SPIN, EVAL, PAYOUT} state_t;
   state_t state, nxt;
   logic [6:0] bet_sel, bet;
   logic [CW-1:0] cnt;
   logic [26:0] payout, pay_calc, jack_sat, credited;
   logic [39:0] jack;
   logic [27:0] sum;
   logic afford, last, four, refuse;
   assign bet_sel  = b1 ? 7'd1 : b10 ? 7'd10 : b50 ? 7'd50 : b100 ? 7'd100 : 7'd0;
   assign afford   = balance >= 27'(bet_sel);
   assign last     = cnt == CW'(4*SPIN_CYCLES-1);
   assign jack     = 40'(bet) * 40'(PAYOUT_MULT);
   assign jack_sat = |jack[39:27] ? BMAX : jack[26:0];
   assign four     = randNum1 == randNum2 && randNum2 == randNum3 && randNum3 == randNum4;
`ifdef SLOT_PAIR_REFUND_EN
   assign pay_calc = four ? jack_sat : (randNum1 == randNum2) ? 27'(bet) : '0;
`else
   assign pay_calc = four ? jack_sat : '0;
`endif
   assign sum      = {1'b0, balance} + {1'b0, payout};
   assign credited = sum[27] ? BMAX : sum[26:0];
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = (spin && bet_sel != 0 && afford) ? DEBIT : IDLE;
         DEBIT:   nxt = SPIN;
         SPIN:    nxt = last ? EVAL : SPIN;
         EVAL:    nxt = PAYOUT;
         default: nxt = IDLE;
      endcase
   end
   always_comb begin
      busy   = state != IDLE;
      refuse = state == IDLE && spin && bet_sel != 0 && !afford;
   end
   // Reel k keeps sampling rnd until the counter passes k*SPIN_CYCLES-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         balance  <= 27'(START_BALANCE);
         randNum1 <= '0;
         randNum2 <= '0;
         randNum3 <= '0;
         randNum4 <= '0;
         cnt      <= '0;
         bet      <= '0;
         payout   <= '0;
         win      <= 1'b0;
         done     <= 1'b0;
         nofunds  <= 1'b0;
      end else begin
         nofunds <= refuse;
         done    <= state == PAYOUT;
         if (state == IDLE && nxt == DEBIT) bet <= bet_sel;
         if (state == DEBIT) begin
            balance <= balance - 27'(bet);
            win     <= 1'b0;
            cnt     <= '0;
         end
         if (state == SPIN) begin
            cnt <= cnt + CW'(1);
            if (cnt < CW'(SPIN_CYCLES))   randNum1 <= rnd;
            if (cnt < CW'(2*SPIN_CYCLES)) randNum2 <= rnd;
            if (cnt < CW'(3*SPIN_CYCLES)) randNum3 <= rnd;
            randNum4 <= rnd;
         end
         if (state == EVAL) payout <= pay_calc;
         if (state == PAYOUT) begin
            balance <= credited;
            win     <= payout != 0;
         end
      end
   end
endmodule

// File: tb/tb_slot_spin_ctrl.sv
// tb_slot_spin_ctrl: table, hand-written and random plays checked against a play-level model.
module tb_slot_spin_ctrl;
   localparam int S = 8;
   localparam int LAST = 3 + 4*S;
   localparam logic [26:0] BMAX = 27'h7FFFFFF;
   localparam logic [26:0] SAT_START = BMAX - 27'd500;
   logic clk = 1'b0, rst, spin, b1, b10, b50, b100;
   logic [3:0] rnd, r1, r2, r3, r4, s1, s2, s3, s4;
   logic [26:0] balance, sbal;
   logic busy, win, done, nofunds, sbusy, swin, sdone, snofunds;
   int tests = 0, fails = 0, obs_debit;
   logic [26:0] mbal;
   typedef struct {
      logic [3:0] sw;
      int mode;
      logic [3:0] cv;
      int exp_debit;
      int exp_final;
      bit exp_win;
   } vec_t;
   vec_t tbl[5];
   slot_spin_ctrl dut (.clk(clk), .rst(rst), .spin(spin), .b1(b1), .b10(b10), .b50(b50), .b100(b100),
      .rnd(rnd), .randNum1(r1), .randNum2(r2), .randNum3(r3), .randNum4(r4), .balance(balance),
      .busy(busy), .win(win), .done(done), .nofunds(nofunds));
   slot_spin_ctrl #(.START_BALANCE(int'(SAT_START))) dut_sat (.clk(clk), .rst(rst), .spin(spin),
      .b1(b1), .b10(b10), .b50(b50), .b100(b100), .rnd(rnd), .randNum1(s1), .randNum2(s2),
      .randNum3(s3), .randNum4(s4), .balance(sbal), .busy(sbusy), .win(swin), .done(sdone),
      .nofunds(snofunds));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic set_sw(input logic [3:0] sw);
      {b1, b10, b50, b100} = sw;
   endtask
   function automatic int bet_of(input logic [3:0] sw);
      if (sw[3]) return 1;
      if (sw[2]) return 10;
      if (sw[1]) return 50;
      if (sw[0]) return 100;
      return 0;
   endfunction
   task automatic do_reset;
      rst = 1'b1;
      spin = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      mbal = 27'd100;
   endtask
   // mode: 0 constant cv, 1 incrementing from cv, 2 pair pattern, 3 random per edge
   task automatic play(input logic [3:0] sw, input int mode, input logic [3:0] cv);
      logic [3:0] seq [0:LAST];
      logic [3:0] f1, f2, f3, f4;
      logic [27:0] sum;
      int bet, pay;
      bit seen;
      bet = bet_of(sw);
      for (int e = 0; e <= LAST; e++)
         seq[e] = mode == 0 ? cv : mode == 1 ? 4'(int'(cv) + e) :
                  mode == 2 ? ((e >= 2 && e < 18) ? 4'd5 : 4'd9) : 4'($urandom);
      set_sw(sw);
      spin = 1'b1;
      rnd = seq[0];
      tick;
      spin = 1'b0;
      if (bet == 0) begin
         check("ignore_busy", busy, 0);
         check("ignore_nofunds", nofunds, 0);
         check("ignore_bal", balance, mbal);
         return;
      end
      if (mbal < 27'(bet)) begin
         check("nofunds_pulse", nofunds, 1);
         check("nofunds_busy", busy, 0);
         check("nofunds_bal", balance, mbal);
         tick;
         check("nofunds_clear", nofunds, 0);
         return;
      end
      check("busy_rise", busy, 1);
      seen = 0;
      for (int e = 1; e <= LAST; e++) begin
         rnd = seq[e];
         if (e == 3) set_sw(~sw);
         tick;
         if (e == 1) begin
            obs_debit = int'(balance);
            check("debit", balance, mbal - 27'(bet));
            check("win_clear", win, 0);
         end
         if (e < LAST) seen = seen | done | !busy;
      end
      check("early_done_or_idle", seen, 0);
      f1 = seq[1+S];
      f2 = seq[1+2*S];
      f3 = seq[1+3*S];
      f4 = seq[1+4*S];
      pay = (f1 == f2 && f2 == f3 && f3 == f4) ? bet * 10 : 0;
`ifdef SLOT_PAIR_REFUND_EN
      if (pay == 0 && f1 == f2) pay = bet;
`endif
      mbal = mbal - 27'(bet);
      sum = 28'(mbal) + 28'(pay);
      mbal = sum > 28'(BMAX) ? BMAX : sum[26:0];
      check("done_pulse", done, 1);
      check("busy_fall", busy, 0);
      check("balance", balance, mbal);
      check("win", win, pay != 0);
      check("reels", {r1, r2, r3, r4}, {f1, f2, f3, f4});
      tick;
      check("done_clear", done, 0);
      check("reels_hold", {r1, r2, r3, r4}, {f1, f2, f3, f4});
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      bit seen;
      int n;
      tbl[0] = '{4'b0100, 0, 4'd7, 90, 190, 1'b1};
      tbl[1] = '{4'b1010, 0, 4'd3, 99, 109, 1'b1};
      tbl[2] = '{4'b0010, 0, 4'd2, 50, 550, 1'b1};
      tbl[3] = '{4'b0001, 1, 4'd0, 0, 0, 1'b0};
`ifdef SLOT_PAIR_REFUND_EN
      tbl[4] = '{4'b0100, 2, 4'd0, 90, 100, 1'b1};
`else
      tbl[4] = '{4'b0100, 2, 4'd0, 90, 90, 1'b0};
`endif
      set_sw(4'b0000);
      rnd = 4'd0;
      do_reset;
      check("rst_balance", balance, 100);
      check("rst_reels", {r1, r2, r3, r4}, 0);
      check("rst_flags", {busy, win, done, nofunds}, 0);
      check("rst_sat_balance", sbal, SAT_START);
      for (int i = 0; i < 5; i++) begin
         do_reset;
         play(tbl[i].sw, tbl[i].mode, tbl[i].cv);
         check("tbl_debit", obs_debit, tbl[i].exp_debit);
         check("tbl_final", balance, tbl[i].exp_final);
         check("tbl_win", win, tbl[i].exp_win);
         if (i == 3) begin
            play(4'b0001, 0, 4'd0);
            check("nofunds_reels", {r1, r2, r3, r4}, {4'd9, 4'd1, 4'd9, 4'd1});
            play(4'b0000, 0, 4'd0);
         end
      end
      // reset during a b50 play
      do_reset;
      set_sw(4'b0010);
      spin = 1'b1;
      tick;
      spin = 1'b0;
      for (int e = 1; e < 10; e++) begin
         rnd = 4'(e);
         tick;
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("midrst_balance", balance, 100);
      check("midrst_reels", {r1, r2, r3, r4}, 0);
      check("midrst_busy", busy, 0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         seen = seen | done;
         tick;
      end
      check("midrst_no_done", seen, 0);
      // saturation on the instance that starts near full scale
      do_reset;
      play(4'b0001, 0, 4'd4);
      check("sat_balance", sbal, BMAX);
      check("sat_win", swin, 1);
      play(4'b0001, 0, 4'd6);
      check("sat_balance_again", sbal, BMAX);
      // spin held high restarts right after done
      do_reset;
      set_sw(4'b0100);
      rnd = 4'd7;
      spin = 1'b1;
      n = 0;
      while (!done && n < 100) begin
         tick;
         n++;
      end
      check("held_done_seen", done, 1);
      check("held_balance", balance, 190);
      tick;
      check("held_restart_busy", busy, 1);
      spin = 1'b0;
      tick;
      check("held_restart_debit", balance, 180);
      n = 0;
      while (!done && n < 100) begin
         tick;
         n++;
      end
      check("held_second_done", done, 1);
      // random plays against the model
      do_reset;
      for (int i = 0; i < 30; i++) begin
         logic [3:0] sw;
         sw = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
         play(sw, ($urandom_range(0, 2) == 0) ? 0 : 3, 4'($urandom));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
